i2s_mix_n: RTL and testbench

Parametrised N-input I2S stereo mixer; generalised successor to the fixed 2-channel add/select block, sitting between N I2S sources sharing one SCK/WS and a single I2S sink. Deserialises WIDTH-bit signed samples per slot from NCH serial inputs and sums the enabled channels with sign extension. Applies a runtime arithmetic attenuation, then saturates or wraps to WIDTH bits. Re-serialises the result as standard I2S, one frame late.

---
 rtl/i2s_mix_pkg.sv | 17 +
 rtl/i2s_slot_rx.sv | 42 ++++
 rtl/i2s_mix_n.sv | 163 ++++++++++++++++
 tb/tb_i2s_mix_n.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_mix_pkg.sv
// Shared defaults, sum-width helper and slot side encoding for the I2S mixer.
package i2s_mix_pkg;

  localparam int unsigned WIDTH_DEF = 24;
  localparam int unsigned NCH_DEF   = 4;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_e;

  // Enough headroom to add NCH full-scale words without overflow.
  function automatic int unsigned sum_w(input int unsigned width, input int unsigned nch);
    return width + $clog2(nch);
  endfunction

endpackage

// File: rtl/i2s_slot_rx.sv
// Single-channel I2S slot deserialiser: MSB taken on the slot start pulse, then one bit per sck.
module i2s_slot_rx
  import i2s_mix_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             sck,
  input  logic             reset,
  input  logic             sp,
  input  logic             sd,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] word_q;
  logic [CntW-1:0]  cnt_q;
  logic             done_q;

  // done_q parks the counter after bit 0 so long slots leave the word untouched.
  always_ff @(posedge sck) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else if (sp) begin
      word_q <= {sd, {(WIDTH-1){1'b0}}};
      cnt_q  <= CntW'(WIDTH - 2);
      done_q <= 1'b0;
    end else if (!done_q) begin
      word_q[cnt_q] <= sd;
      if (cnt_q == '0) begin
        done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign word = word_q;

endmodule

// File: rtl/i2s_mix_n.sv
// N-input I2S stereo mixer: sum of enabled channels, arithmetic attenuation, one-frame latency.
// Define I2S_MIX_SAT_EN to clamp the mix and drive clip; otherwise the mix wraps and clip is 0.
module i2s_mix_n
  import i2s_mix_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned ATT_W = 3
) (
  input  logic             sck,
  input  logic             reset,
  input  logic             ws,
  input  logic [NCH-1:0]   sd_in,
  input  logic [NCH-1:0]   ch_en,
  input  logic [ATT_W-1:0] att,
  output logic             sd_out,
  output logic             ws_out,
  output logic             clip
);

  localparam int unsigned SUM_W = sum_w(WIDTH, NCH);

  logic wsd, wsd_q, sp, sp_q, rst_q;

  always_ff @(posedge sck) begin
    rst_q <= reset;
    if (reset) begin
      wsd   <= 1'b0;
      wsd_q <= 1'b0;
      sp_q  <= 1'b0;
    end else begin
      wsd   <= ws;
      wsd_q <= wsd;
      sp_q  <= sp;
    end
  end

  assign sp = wsd ^ wsd_q;

  logic [NCH-1:0][WIDTH-1:0] word;

  for (genvar c = 0; c < NCH; c++) begin : g_rx
    i2s_slot_rx #(
      .WIDTH(WIDTH)
    ) u_rx (
      .sck  (sck),
      .reset(reset),
      .sp   (sp),
      .sd   (sd_in[c]),
      .word (word[c])
    );
  end

  // Hold stage: words of the slot just completed plus the controls that apply to them.
  logic [NCH-1:0][WIDTH-1:0] hold_word;
  logic [NCH-1:0]            hold_en;
  logic [ATT_W-1:0]          hold_att;
  side_e                     hold_side;

  always_ff @(posedge sck) begin
    if (reset) begin
      hold_word <= '0;
      hold_en   <= '0;
      hold_att  <= '0;
      hold_side <= LEFT;
    end else if (sp) begin
      hold_word <= word;
      hold_en   <= ch_en;
      hold_att  <= att;
      hold_side <= side_e'(~wsd);
    end
  end

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic [WIDTH-1:0]        mix_val;

  always_comb begin
    sum = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      if (hold_en[c]) begin
        sum = sum + signed'({{(SUM_W-WIDTH){hold_word[c][WIDTH-1]}}, hold_word[c]});
      end
    end
  end

  assign shifted = sum >>> hold_att;

`ifdef I2S_MIX_SAT_EN
  logic [SUM_W-WIDTH:0] head;
  logic                 sat_hit;

  // The result fits in WIDTH bits only when the head bits are a pure sign extension.
  assign head = shifted[SUM_W-1:WIDTH-1];

  always_comb begin
    sat_hit = 1'b0;
    mix_val = shifted[WIDTH-1:0];
    if (!((&head) || !(|head))) begin
      sat_hit = 1'b1;
      mix_val = shifted[SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_head;

  assign unused_head = ^shifted[SUM_W-1:WIDTH];
  assign mix_val     = shifted[WIDTH-1:0];
`endif

  logic [WIDTH-1:0] mix_l, mix_r;

  always_ff @(posedge sck) begin
    if (reset) begin
      mix_l <= '0;
      mix_r <= '0;
    end else if (sp_q) begin
      if (hold_side == LEFT) begin
        mix_l <= mix_val;
      end else begin
        mix_r <= mix_val;
      end
    end
  end

`ifdef I2S_MIX_SAT_EN
  logic clip_q;

  always_ff @(posedge sck) begin
    if (reset) begin
      clip_q <= 1'b0;
    end else begin
      clip_q <= sp_q & sat_hit;
    end
  end

  assign clip = clip_q;
`else
  assign clip = 1'b0;
`endif

  // Transmit side. Loading one falling edge after ws_out toggles gives the I2S 1-bit offset.
  logic [WIDTH-1:0] sh_q;
  logic             ws_out_q;

  always_ff @(negedge sck) begin
    if (rst_q) begin
      sh_q     <= '0;
      ws_out_q <= 1'b0;
    end else begin
      ws_out_q <= wsd;
      if (sp_q) begin
        sh_q <= (side_e'(wsd) == RIGHT) ? mix_r : mix_l;
      end else begin
        sh_q <= {sh_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign sd_out = sh_q[WIDTH-1];
  assign ws_out = ws_out_q;

endmodule

// File: tb/tb_i2s_mix_n.sv
// Directed bench for i2s_mix_n: drives I2S frames on all inputs and deserialises sd_out/ws_out.
module tb_i2s_mix_n;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned NCH   = 4;
  localparam int unsigned ATT_W = 3;

`ifdef I2S_MIX_SAT_EN
  localparam logic [WIDTH-1:0] EXP_POS   = 24'h7FFFFF;
  localparam logic [WIDTH-1:0] EXP_NEG   = 24'h800000;
  localparam int               EXP_CLIPS = 2;
`else
  localparam logic [WIDTH-1:0] EXP_POS   = 24'hFFFFFE;
  localparam logic [WIDTH-1:0] EXP_NEG   = 24'h000000;
  localparam int               EXP_CLIPS = 0;
`endif

  logic             sck = 1'b0;
  logic             reset;
  logic             ws;
  logic [NCH-1:0]   sd_in;
  logic [NCH-1:0]   ch_en;
  logic [ATT_W-1:0] att;
  logic             sd_out;
  logic             ws_out;
  logic             clip;

  i2s_mix_n #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .ATT_W(ATT_W)
  ) dut (
    .sck   (sck),
    .reset (reset),
    .ws    (ws),
    .sd_in (sd_in),
    .ch_en (ch_en),
    .att   (att),
    .sd_out(sd_out),
    .ws_out(ws_out),
    .clip  (clip)
  );

  always #5 sck = ~sck;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] l_word [NCH];
  logic [WIDTH-1:0] r_word [NCH];
  logic [NCH-1:0]   prev_bit = '0;

  logic             mon_on = 1'b0;
  logic             mon_ws = 1'b0;
  int               bcnt = 0;
  logic [WIDTH-1:0] mw = '0;
  logic [WIDTH-1:0] last_l = '0;
  logic [WIDTH-1:0] last_r = '0;
  logic [WIDTH-1:0] cap_q [$];
  int               clip_cnt = 0;
  logic             rst_prev = 1'b0;
  logic             post_rst_sd = 1'b1;
  logic             post_rst_ws = 1'b1;

  // One sck: sample outputs after the falling edge, then drive this bit's inputs.
  task automatic step(input logic side, input logic [NCH-1:0] bits, input logic rst);
    @(negedge sck);
    #1;
    if (rst_prev) begin
      post_rst_sd = sd_out;
      post_rst_ws = ws_out;
      mon_on      = 1'b0;
      mon_ws      = ws_out;
      cap_q.delete();
    end else begin
      if (mon_on && bcnt < int'(WIDTH)) mw[WIDTH-1-bcnt] = sd_out;
      bcnt++;
      if (ws_out != mon_ws) begin
        if (mon_on) begin
          if (mon_ws) last_r = mw;
          else last_l = mw;
          cap_q.push_back(mw);
        end
        mon_on = 1'b1;
        bcnt   = 0;
        mw     = '0;
        mon_ws = ws_out;
      end
    end
    if (clip === 1'b1) clip_cnt++;
    reset    = rst;
    rst_prev = rst;
    ws       = side;
    sd_in    = prev_bit;
    prev_bit = bits;
  endtask

  task automatic run_frame(input int slot, input int rst_at);
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < slot; j++) begin
        logic [NCH-1:0] b;
        for (int c = 0; c < int'(NCH); c++) begin
          if (j < int'(WIDTH)) b[c] = (s == 0) ? l_word[c][WIDTH-1-j] : r_word[c][WIDTH-1-j];
          else b[c] = 1'b0;
        end
        step(s[0], b, (s == 0 && j == rst_at));
      end
    end
  endtask

  task automatic set_ch(input int c, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    l_word[c] = l;
    r_word[c] = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ws    = 1'b0;
    sd_in = '0;
    ch_en = '0;
    att   = '0;
    for (int c = 0; c < int'(NCH); c++) set_ch(c, '0, '0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    checks++;
    if (post_rst_sd !== 1'b0) begin
      errors++;
      $display("FAIL reset_sd_out: got %b expected 0", post_rst_sd);
    end
    checks++;
    if (post_rst_ws !== 1'b0) begin
      errors++;
      $display("FAIL reset_ws_out: got %b expected 0", post_rst_ws);
    end
    checks++;
    if (clip !== 1'b0) begin
      errors++;
      $display("FAIL reset_clip: got %b expected 0", clip);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq[0] = 24'h000000;
    exp_seq[1] = 24'h000000;
    exp_seq[2] = 24'hFEDCBA;
    exp_seq[3] = 24'h123456;
    ch_en = 4'b0001;
    att   = '0;
    set_ch(0, 24'h123456, 24'hFEDCBA);
    for (int c = 1; c < int'(NCH); c++) set_ch(c, 24'h7FFFFF, 24'h5A5A5A);
    cap_q.delete();
    for (int f = 0; f < 4; f++) run_frame(32, -1);
    if (cap_q.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL basic_count: got %0d words expected at least 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_q[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL basic_word%0d: got %h expected %h", i, cap_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_sum_att();
    ch_en = 4'b1111;
    att   = '0;
    for (int c = 0; c < int'(NCH); c++) set_ch(c, 24'h100000, 24'h000010);
    for (int f = 0; f < 3; f++) run_frame(32, -1);
    checks++;
    if (last_l !== 24'h400000) begin
      errors++;
      $display("FAIL sum4_left: got %h expected 400000", last_l);
    end
    checks++;
    if (last_r !== 24'h000040) begin
      errors++;
      $display("FAIL sum4_right: got %h expected 000040", last_r);
    end
    att = 3'd2;
    for (int f = 0; f < 3; f++) run_frame(32, -1);
    checks++;
    if (last_l !== 24'h100000) begin
      errors++;
      $display("FAIL att2_left: got %h expected 100000", last_l);
    end
    checks++;
    if (last_r !== 24'h000010) begin
      errors++;
      $display("FAIL att2_right: got %h expected 000010", last_r);
    end
  endtask

  task automatic test_sat_pos();
    ch_en = 4'b0011;
    att   = '0;
    for (int c = 0; c < int'(NCH); c++) set_ch(c, (c < 2) ? 24'h7FFFFF : 24'h000000, '0);
    run_frame(32, -1);
    clip_cnt = 0;
    run_frame(32, -1);
    run_frame(32, -1);
    checks++;
    if (last_l !== EXP_POS) begin
      errors++;
      $display("FAIL pos_over_left: got %h expected %h", last_l, EXP_POS);
    end
    checks++;
    if (last_r !== 24'h000000) begin
      errors++;
      $display("FAIL pos_over_right: got %h expected 000000", last_r);
    end
    checks++;
    if (clip_cnt != EXP_CLIPS) begin
      errors++;
      $display("FAIL pos_clip_count: got %0d expected %0d", clip_cnt, EXP_CLIPS);
    end
  endtask

  task automatic test_sat_neg();
    ch_en = 4'b0011;
    att   = '0;
    for (int c = 0; c < int'(NCH); c++) set_ch(c, (c < 2) ? 24'h800000 : 24'h000000, '0);
    run_frame(32, -1);
    clip_cnt = 0;
    run_frame(32, -1);
    run_frame(32, -1);
    checks++;
    if (last_l !== EXP_NEG) begin
      errors++;
      $display("FAIL neg_over_left: got %h expected %h", last_l, EXP_NEG);
    end
    checks++;
    if (clip_cnt != EXP_CLIPS) begin
      errors++;
      $display("FAIL neg_clip_count: got %0d expected %0d", clip_cnt, EXP_CLIPS);
    end
    ch_en = 4'b0001;
    att   = 3'd1;
    for (int f = 0; f < 3; f++) run_frame(32, -1);
    checks++;
    if (last_l !== 24'hC00000) begin
      errors++;
      $display("FAIL neg_att1_left: got %h expected c00000", last_l);
    end
  endtask

  task automatic test_slot_len();
    ch_en = 4'b0001;
    att   = '0;
    set_ch(0, 24'h123456, 24'hFEDCBA);
    for (int c = 1; c < int'(NCH); c++) set_ch(c, 24'h0F0F0F, 24'h0F0F0F);
    for (int f = 0; f < 3; f++) run_frame(24, -1);
    checks++;
    if (last_l !== 24'h123456) begin
      errors++;
      $display("FAIL slot24_left: got %h expected 123456", last_l);
    end
    checks++;
    if (last_r !== 24'hFEDCBA) begin
      errors++;
      $display("FAIL slot24_right: got %h expected fedcba", last_r);
    end
    for (int f = 0; f < 3; f++) run_frame(16, -1);
    checks++;
    if (last_l !== 24'h123400) begin
      errors++;
      $display("FAIL slot16_left: got %h expected 123400", last_l);
    end
    checks++;
    if (last_r !== 24'hFEDC00) begin
      errors++;
      $display("FAIL slot16_right: got %h expected fedc00", last_r);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] exp_seq [4];
    exp_seq[0] = 24'h000000;
    exp_seq[1] = 24'h000000;
    exp_seq[2] = 24'h123456;
    exp_seq[3] = 24'hFFFFFF;
    ch_en = 4'b0001;
    att   = '0;
    set_ch(0, 24'hFFFFFF, 24'h123456);
    run_frame(32, -1);
    run_frame(32, -1);
    post_rst_sd = 1'b1;
    post_rst_ws = 1'b1;
    run_frame(32, 8);
    checks++;
    if (post_rst_sd !== 1'b0) begin
      errors++;
      $display("FAIL midreset_sd_out: got %b expected 0", post_rst_sd);
    end
    checks++;
    if (post_rst_ws !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ws_out: got %b expected 0", post_rst_ws);
    end
    for (int f = 0; f < 3; f++) run_frame(32, -1);
    if (cap_q.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL midreset_count: got %0d words expected at least 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_q[i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL midreset_word%0d: got %h expected %h", i, cap_q[i], exp_seq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sum_att();
    test_sat_pos();
    test_sat_neg();
    test_slot_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
